seven_seg_capture: RTL and testbench

//  Inverse of the board's hex->7-segment encoder: samples an external multiplexed,

---
 rtl/seven_seg_capture_if.sv | 26 ++
 rtl/seven_seg_capture.sv | 191 +++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
`default_nettype none
// =====================================================================
// seven_seg_capture_if: display bus in, decoded frame out
// Revision: 1.0
// =====================================================================
interface seven_seg_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_sel_n;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    frame_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic [NUM_DIGITS-1:0]   digit_blank;

  modport master (
    output seg_n, dig_sel_n,
    input  value, frame_valid, digit_err, digit_blank
  );

  modport slave (
    input  seg_n, dig_sel_n,
    output value, frame_valid, digit_err, digit_blank
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// =====================================================================
// seven_seg_capture: samples a multiplexed active-low 7-segment bus and
// rebuilds the displayed hex frame.  Revision: 1.0
// =====================================================================
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seven_seg_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int SW = 7 + NUM_DIGITS;

  logic [6:0]              seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q;
  logic [SW-1:0]           prev_q;
  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    capture;

  logic [4*NUM_DIGITS-1:0] shadow_val_q;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_blank_q;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   err_q, blank_q;
  logic                    fv_q;

  logic [SW-1:0]           sample;
  logic                    same;
  logic                    sel_valid;
  logic [NUM_DIGITS-1:0]   dig_hot;
  logic [5:0]              dec;
  logic                    frame_full;

  // Result layout: {blank, err, nibble}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b00_0000;
    case (p)
      7'h3F: r[3:0] = 4'h0;
      7'h06: r[3:0] = 4'h1;
      7'h5B: r[3:0] = 4'h2;
      7'h4F: r[3:0] = 4'h3;
      7'h66: r[3:0] = 4'h4;
      7'h6D: r[3:0] = 4'h5;
      7'h7D: r[3:0] = 4'h6;
      7'h07: r[3:0] = 4'h7;
      7'h7F: r[3:0] = 4'h8;
      7'h6F: r[3:0] = 4'h9;
      7'h77: r[3:0] = 4'hA;
      7'h7C: r[3:0] = 4'hB;
      7'h58: r[3:0] = 4'hC;
      7'h5E: r[3:0] = 4'hD;
      7'h79: r[3:0] = 4'hE;
      7'h71: r[3:0] = 4'hF;
      7'h00: r[5]   = 1'b1;
      default: r[4] = 1'b1;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= 7'h7F;
      seg_s2_q <= 7'h7F;
      sel_s1_q <= '1;
      sel_s2_q <= '1;
    end else begin
      seg_s1_q <= bus.seg_n;
      seg_s2_q <= seg_s1_q;
      sel_s1_q <= bus.dig_sel_n;
      sel_s2_q <= sel_s1_q;
    end
  end

  assign sample     = {seg_s2_q, sel_s2_q};
  assign same       = (sample == prev_q);
  assign dig_hot    = ~sel_s2_q;
  assign sel_valid  = $onehot(dig_hot);
  assign dec        = decode(~seg_s2_q);
  assign frame_full = &mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      prev_q  <= {7'h7F, {NUM_DIGITS{1'b1}}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sample;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d = S_COUNT;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      S_COUNT: begin
        if (same) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(STABLE_CYCLES)) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end else if (sel_valid) begin
          cnt_d = 8'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      S_HOLD: begin
        if (!same) begin
          if (sel_valid) begin
            state_d = S_COUNT;
            cnt_d   = 8'd1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // The mask clears on the copy cycle, but a simultaneous capture still lands in the new frame.
  always_comb begin
    mask_d = frame_full ? '0 : mask_q;
    if (capture) begin
      mask_d = mask_d | dig_hot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_q   <= '0;
      shadow_err_q   <= '0;
      shadow_blank_q <= '0;
      mask_q         <= '0;
      value_q        <= '0;
      err_q          <= '0;
      blank_q        <= '0;
      fv_q           <= 1'b0;
    end else begin
      mask_q <= mask_d;
      fv_q   <= frame_full;
      if (frame_full) begin
        value_q <= shadow_val_q;
        err_q   <= shadow_err_q;
        blank_q <= shadow_blank_q;
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && dig_hot[k]) begin
          shadow_val_q[4*k +: 4] <= dec[3:0];
          shadow_err_q[k]        <= dec[4];
          shadow_blank_q[k]      <= dec[5];
        end
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = fv_q;
  assign bus.digit_err   = err_q;
  assign bus.digit_blank = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// =====================================================================
// tb_seven_seg_capture: directed and random stimulus against a run-length
// reference model of the capture rules.  Revision: 1.0
// =====================================================================
module tb_seven_seg_capture;
  localparam int ND = 4;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_seen = 1'b0;
  always #5 clk = ~clk;

  seven_seg_capture_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int model_diff = 0;

  logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [6:0]  m_s1_seg, m_s2_seg, m_prev_seg, in_seg;
  logic [3:0]  m_s1_sel, m_s2_sel, m_prev_sel, in_sel;
  int          m_run;
  logic [3:0]  m_mask;
  logic [3:0]  m_sh [ND];
  logic [3:0]  m_sh_err, m_sh_blank;
  logic [15:0] m_val;
  logic [3:0]  m_err, m_blank;
  logic        m_fv;
  logic [23:0] dq[$];
  logic [23:0] mq[$];

  function automatic logic [6:0] seg_of(input int h);
    return ~PAT[h];
  endfunction

  function automatic logic [3:0] sel_of(input int d);
    logic [3:0] s;
    s = 4'hF;
    s[d] = 1'b0;
    return s;
  endfunction

  // {blank, err, nibble}
  function automatic logic [5:0] ref_decode(input logic [6:0] segn);
    logic [6:0] p;
    p = ~segn;
    if (p == 7'h00) return 6'b10_0000;
    for (int i = 0; i < 16; i++) if (PAT[i] == p) return {2'b00, 4'(i)};
    return 6'b01_0000;
  endfunction

  task automatic model_reset();
    m_s1_seg = 7'h7F; m_s2_seg = 7'h7F; m_prev_seg = 7'h7F;
    m_s1_sel = 4'hF;  m_s2_sel = 4'hF;  m_prev_sel = 4'hF;
    m_run = 0; m_mask = 4'h0; m_sh_err = 4'h0; m_sh_blank = 4'h0;
    for (int k = 0; k < ND; k++) m_sh[k] = 4'h0;
    m_val = 16'h0; m_err = 4'h0; m_blank = 4'h0; m_fv = 1'b0;
  endtask

  task automatic model_step();
    logic [5:0] d;
    bit cap;
    if ({m_s2_seg, m_s2_sel} == {m_prev_seg, m_prev_sel}) m_run++;
    else m_run = 1;
    cap = ($countones(~m_s2_sel) == 1) && (m_run == SC);
    d = ref_decode(m_s2_seg);
    m_fv = 1'b0;
    if (m_mask == 4'hF) begin
      for (int k = 0; k < ND; k++) m_val[4*k +: 4] = m_sh[k];
      m_err = m_sh_err; m_blank = m_sh_blank; m_fv = 1'b1; m_mask = 4'h0;
    end
    if (cap) begin
      for (int k = 0; k < ND; k++) begin
        if (!m_s2_sel[k]) begin
          m_sh[k] = d[3:0]; m_sh_err[k] = d[4]; m_sh_blank[k] = d[5]; m_mask[k] = 1'b1;
        end
      end
    end
    m_prev_seg = m_s2_seg; m_prev_sel = m_s2_sel;
    m_s2_seg = m_s1_seg;   m_s2_sel = m_s1_sel;
    m_s1_seg = in_seg;     m_s1_sel = in_sel;
  endtask

  initial forever begin
    @(posedge clk);
    rst_seen = rst_n;
  end

  initial begin
    model_reset();
    in_seg = 7'h7F;
    in_sel = 4'hF;
    forever begin
      @(negedge clk);
      if (!rst_n || !rst_seen) model_reset();
      else model_step();
      if ({bus.frame_valid, bus.value, bus.digit_err, bus.digit_blank} !==
          {m_fv, m_val, m_err, m_blank}) model_diff++;
      if (bus.frame_valid === 1'b1) dq.push_back({bus.digit_blank, bus.digit_err, bus.value});
      if (m_fv) mq.push_back({m_blank, m_err, m_val});
      in_seg = bus.seg_n;
      in_sel = bus.dig_sel_n;
    end
  end

  task automatic hold(input logic [6:0] s, input logic [3:0] sel, input int n);
    @(posedge clk);
    #1;
    bus.seg_n = s;
    bus.dig_sel_n = sel;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic frame4(input logic [6:0] s0, s1, s2, s3, input int n);
    hold(s0, sel_of(0), n);
    hold(s1, sel_of(1), n);
    hold(s2, sel_of(2), n);
    hold(s3, sel_of(3), n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.seg_n = 7'h7F;
    bus.dig_sel_n = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dq.delete();
    mq.delete();
  endtask

  task automatic test_reset();
    logic [24:0] o;
    bus.seg_n = 7'h7F;
    bus.dig_sel_n = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    o = {bus.frame_valid, bus.digit_blank, bus.digit_err, bus.value};
    total++;
    if (o !== 25'h0) begin bad++; $display("FAIL reset_power_on: got %h want 0", o); end
    rst_n = 1'b1;
    frame4(7'h30, 7'h08, 7'h40, 7'h78, 20);
    total++;
    if (bus.value !== 16'h70A3) begin bad++; $display("FAIL reset_preframe: got %h want 70a3", bus.value); end
    hold(7'h79, sel_of(0), 20);
    hold(7'h24, sel_of(1), 20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o = {bus.frame_valid, bus.digit_blank, bus.digit_err, bus.value};
    total++;
    if (o !== 25'h0) begin bad++; $display("FAIL reset_midclock: got %h want 0", o); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dq.delete();
    mq.delete();
    hold(7'h12, sel_of(2), 20);
    hold(7'h30, sel_of(3), 20);
    hold(7'h7F, 4'hF, 10);
    total++;
    if (dq.size() !== 0) begin bad++; $display("FAIL reset_no_stale: got %0d frames want 0", dq.size()); end
    frame4(7'h79, 7'h24, 7'h12, 7'h30, 20);
    total++;
    if (dq.size() !== 1 || dq[0] !== 24'h00_3521) begin
      bad++; $display("FAIL reset_next_frame: got n=%0d %h want n=1 003521", dq.size(), dq.size() ? dq[0] : 24'h0);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    frame4(7'h30, 7'h08, 7'h40, 7'h78, 20);
    total++;
    if (dq.size() !== 1) begin bad++; $display("FAIL full_count: got %0d want 1", dq.size()); end
    else begin
      total++;
      if (dq[0] !== 24'h00_70A3) begin bad++; $display("FAIL full_value: got %h want 0070a3", dq[0]); end
    end
    total++;
    if (model_diff !== 0) begin bad++; $display("FAIL full_model: got %0d diffs want 0", model_diff); end
  endtask

  task automatic test_glitch();
    do_reset();
    hold(7'h79, sel_of(0), 20);
    hold(7'h08, sel_of(1), 5);
    hold(7'h40, sel_of(1), 20);
    hold(7'h24, sel_of(2), 20);
    hold(7'h12, sel_of(3), 20);
    total++;
    if (dq.size() !== 1 || dq[0] !== 24'h00_5201) begin
      bad++; $display("FAIL glitch: got n=%0d %h want n=1 005201", dq.size(), dq.size() ? dq[0] : 24'h0);
    end
  endtask

  task automatic test_err_blank();
    do_reset();
    frame4(7'h79, 7'h24, 7'h7E, 7'h7F, 20);
    total++;
    if (dq.size() !== 1 || dq[0] !== {4'b1000, 4'b0100, 16'h0021}) begin
      bad++; $display("FAIL err_blank: got n=%0d %h want n=1 840021", dq.size(), dq.size() ? dq[0] : 24'h0);
    end
  endtask

  task automatic test_invalid_select();
    do_reset();
    hold(7'h30, sel_of(0), 20);
    hold(7'h00, 4'b1111, 50);
    hold(7'h00, 4'b1100, 50);
    total++;
    if (dq.size() !== 0) begin bad++; $display("FAIL invalid_nocap: got %0d frames want 0", dq.size()); end
    hold(7'h79, sel_of(1), 20);
    hold(7'h24, sel_of(2), 20);
    hold(7'h12, sel_of(3), 20);
    total++;
    if (dq.size() !== 1 || dq[0] !== 24'h00_5213) begin
      bad++; $display("FAIL invalid_mask_kept: got n=%0d %h want n=1 005213", dq.size(), dq.size() ? dq[0] : 24'h0);
    end
  endtask

  task automatic test_exhaustive();
    logic [23:0] want;
    do_reset();
    for (int h = 0; h < 8; h++) begin
      frame4(seg_of(h), 7'h79, 7'h24, 7'h12, 20);
      want = {8'h00, 12'h521, 4'(h)};
      total++;
      if (dq.size() !== 1 || dq[0] !== want) begin
        bad++; $display("FAIL exh_pre h=%0d: got n=%0d %h want %h", h, dq.size(), dq.size() ? dq[0] : 24'h0, want);
      end
      dq.delete();
    end
    hold(seg_of(8), sel_of(0), 20);
    hold(7'h79, sel_of(1), 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++;
    if (dq.size() !== 0) begin bad++; $display("FAIL exh_partial: got %0d frames want 0", dq.size()); end
    for (int h = 0; h < 16; h++) begin
      frame4(seg_of(h), 7'h79, 7'h24, 7'h12, 20);
      want = {8'h00, 12'h521, 4'(h)};
      total++;
      if (dq.size() !== 1 || dq[0] !== want) begin
        bad++; $display("FAIL exh_post h=%0d: got n=%0d %h want %h", h, dq.size(), dq.size() ? dq[0] : 24'h0, want);
      end
      dq.delete();
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [3:0] sel;
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 85) sel = sel_of($urandom_range(0, ND - 1));
      else sel = 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 75) s = seg_of($urandom_range(0, 15));
      else if (r < 85) s = 7'h7F;
      else s = 7'($urandom);
      hold(s, sel, $urandom_range(1, 24));
    end
    hold(7'h7F, 4'hF, 30);
    total++;
    if (model_diff !== 0) begin bad++; $display("FAIL rand_cycle: got %0d diffs want 0", model_diff); end
    total++;
    if (dq.size() < 1) begin bad++; $display("FAIL rand_frames: got %0d want >0", dq.size()); end
    total++;
    if (dq.size() !== mq.size()) begin
      bad++; $display("FAIL rand_count: got %0d want %0d", dq.size(), mq.size());
    end else begin
      for (int i = 0; i < dq.size(); i++) begin
        total++;
        if (dq[i] !== mq[i]) begin bad++; $display("FAIL rand_frame%0d: got %h want %h", i, dq[i], mq[i]); end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.seg_n = 7'h7F;
    bus.dig_sel_n = 4'hF;
    test_reset();
    test_full_frame();
    test_glitch();
    test_err_blank();
    test_invalid_select();
    test_exhaustive();
    test_random();
    total++;
    if (model_diff !== 0) begin bad++; $display("FAIL model_total: got %0d diffs want 0", model_diff); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
